// File: rtl/ifetch.sv
// ifetch: instruction fetch sequencer.
//   Fetches one instruction word from instruction memory, presents it to the
//   controller, then advances the pc. The pc goes to the redirect target on a
//   jump or a taken branch-if-zero, and to pc+1 otherwise.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   en             run enable, checked on leaving IDLE and on leaving ISSUE
//   imem_req/addr  memory read request and address (the address is the pc)
//   imem_ack/rdata memory read-data strobe and data, accepted only in FETCH
//   stall          downstream hold; freezes the block while in ISSUE
//   jump, branch, acc_zero, target
//                  redirect decode from the controller, used in ISSUE
//   instr_valid    op/operand hold a fetched instruction
//   op, operand    opcode and immediate/address field of that instruction
//   pc             address of the presented or in-flight instruction
//   instr_count    number of retired instructions, wrapping at 16 bits
//
// state | meaning
// IDLE  | not running; waiting for en
// FETCH | read request outstanding; waiting for imem_ack
// ISSUE | instruction presented; retires when stall is low
module ifetch #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               jump,
  input  logic               branch,
  input  logic               acc_zero,
  input  logic [PC_W-1:0]    target,
  output logic               instr_valid,
  output logic [3:0]         op,
  output logic [PC_W-1:0]    operand,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt;
  logic [15:0]        count_nxt;

  // Reset wins over everything, so an ack that arrives with rst is dropped,
  // and a late ack after reset lands in IDLE, where it is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= '0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ir          <= ir_nxt;
      instr_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    count_nxt   = instr_count;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = FETCH;
      end
      FETCH: begin
        // en is not checked here, so a request that has been issued always completes.
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_nxt    = imem_rdata;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          // Jump and taken branch both redirect, so jump wins when both are set.
          if (jump || (branch && acc_zero)) pc_nxt = target;
          else                              pc_nxt = pc + PC_W'(1);
          count_nxt = instr_count + 16'd1;
          state_nxt = en ? FETCH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign op        = ir[INSTR_W-1 -: 4];
  assign operand   = ir[PC_W-1:0];

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter PC_W, default 12, SHALL set the program counter and instruction-address width.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction word width; bits [INSTR_W-1:INSTR_W-4] are the opcode and bits [PC_W-1:0] are the operand.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-005 en  input  1  SHALL be the run enable; fetching starts only while en=1.
REQ-006 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-007 imem_addr  output  PC_W  SHALL be the instruction-memory read address.
REQ-008 imem_ack  input  1  SHALL be the memory read-data-valid strobe.
REQ-009 imem_rdata  input  INSTR_W  SHALL be the memory read data.
REQ-010 stall  input  1  SHALL be the downstream hold request.
REQ-011 jump  input  1  SHALL be the controller jump decode for the presented instruction.
REQ-012 branch  input  1  SHALL be the controller branch-if-zero decode for the presented instruction.
REQ-013 acc_zero  input  1  SHALL be the accumulator-equals-zero flag.
REQ-014 target  input  PC_W  SHALL be the jump or branch destination.
REQ-015 instr_valid  output  1  SHALL flag that op and operand hold a fetched instruction.
REQ-016 op  output  4  SHALL be the opcode presented to the controller.
REQ-017 operand  output  PC_W  SHALL be the immediate or address field of the presented instruction.
REQ-018 pc  output  PC_W  SHALL be the address of the presented or in-flight instruction.
REQ-019 instr_count  output  16  SHALL be the count of retired (issued) instructions.

Function
REQ-020 The block SHALL use states IDLE, FETCH and ISSUE.
REQ-021 IDLE: imem_req=0 and instr_valid=0; the block SHALL move to FETCH on the next edge when en=1.
REQ-022 FETCH: imem_req=1 and imem_addr=pc; the block SHALL wait any number of cycles for imem_ack.
REQ-023 FETCH with imem_ack=1: the block SHALL latch imem_rdata into the instruction register and enter ISSUE on the same edge.
REQ-024 imem_ack SHALL be ignored in IDLE and ISSUE.
REQ-025 ISSUE: instr_valid=1, imem_req=0, and op/operand SHALL be driven from the instruction register.
REQ-026 jump, branch, acc_zero and target SHALL be sampled only in ISSUE cycles with stall=0.
REQ-027 ISSUE with stall=1: the block SHALL hold all state and outputs unchanged.
REQ-028 ISSUE with stall=0: the block SHALL load pc with target if jump=1 or (branch=1 and acc_zero=1), and with pc+1 otherwise.
REQ-029 pc+1 SHALL wrap modulo 2^PC_W.
REQ-030 ISSUE with stall=0: instr_count SHALL increment by 1, wrapping modulo 2^16.
REQ-031 ISSUE with stall=0: the next state SHALL be FETCH if en=1 and IDLE if en=0.
REQ-032 Minimum throughput: one instruction per 2 cycles when imem_ack is asserted in the first FETCH cycle.
REQ-033 en=0 during FETCH SHALL NOT abort the outstanding request; the en check applies only at ISSUE exit.
REQ-034 When jump=1 and branch=1 together, jump SHALL take priority (result: pc<=target).
REQ-035 Opcode 0000 (NOP) SHALL issue like any other instruction and take the pc+1 path.

Reset
REQ-036 rst=1 SHALL force, on the next edge: state=IDLE, pc=0, instruction register=0, instr_count=0, imem_req=0, instr_valid=0, op=0, operand=0.
REQ-037 rst SHALL take priority over every other input, including an imem_ack in the same cycle.
REQ-038 An outstanding fetch SHALL be abandoned on reset; no late acknowledge from it is accepted until the block next enters FETCH.

Verification
REQ-039 Reset, then en=1, memory acks in the first FETCH cycle, rdata=0x8005 at address 0 -> in ISSUE: op=1000, operand=0x005, pc=0; next imem_addr=1; instr_count=1.
REQ-040 Memory acks after 3 wait cycles -> imem_req stays 1 with a stable imem_addr for 3 cycles; instr_valid asserts the cycle after the ack.
REQ-041 ISSUE with jump=1, target=0x0A0 -> next imem_addr=0x0A0. ISSUE with branch=1, acc_zero=0 -> pc+1. ISSUE with branch=1, acc_zero=1, target=0x010 -> 0x010.
REQ-042 stall=1 held for 4 ISSUE cycles -> op, operand and pc stay constant and instr_count does not change; the fetch proceeds the cycle after stall drops.
REQ-043 pc=0xFFF, ISSUE with no redirect -> next imem_addr=0x000.
REQ-044 rst asserted during FETCH in the same cycle as imem_ack -> state=IDLE, pc=0, instr_valid=0; the acknowledged data is not latched.
